dmem_arbiter: RTL and testbench

//   Shares the single-port 256x16 data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/debug burst port.
//   The CPU normally wins single-cycle accesses. A starvation counter guarantees DMA service after MAX_WAIT lost cycles.
//   DMA bursts are atomic, and the CPU is stalled for their duration.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_burst_ctr.sv | 52 +++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM encoding
// and the burst-length decode helper.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 16;
    localparam int LEN_W_DEF    = 4;
    localparam int MAX_WAIT_DEF = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // A zero length field encodes the longest burst, 2**len_w words.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned len_w);
        if (len == 32'd0) begin
            return 32'd1 << len_w;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/debug port, the arbiter and Data_Memory.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]  dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;
    logic              dma_done;

    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_dataout;
    logic [DATA_W-1:0] d_datain;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_rdata, dma_ack, dma_done,
        output d_we, d_addr, d_dataout,
        input  d_datain
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_rdata, dma_ack, dma_done,
        input  d_we, d_addr, d_dataout,
        output d_datain
    );

endinterface

// File: rtl/dmem_burst_ctr.sv
// Burst bookkeeping: latches base/direction/length at grant, counts beats and
// produces the wrapped beat address plus the last-beat flag.
module dmem_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    input  logic              start_s,
    input  logic              advance_s,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    output logic [ADDR_W-1:0] beat_addr_s,
    output logic              we_lat_s,
    output logic              last_beat_s,
    output logic              single_s
);

    logic [ADDR_W-1:0] base_r;
    logic [LEN_W-1:0]  len_r;
    logic              we_r;
    logic [LEN_W-1:0]  beat_r;

    // Grant latches the burst descriptor; beat 0 is issued in the grant cycle itself.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= {ADDR_W{1'b0}};
            len_r  <= {LEN_W{1'b0}};
            we_r   <= 1'b0;
            beat_r <= {LEN_W{1'b0}};
        end else if (start_s) begin
            base_r <= dma_addr;
            len_r  <= dma_len;
            we_r   <= dma_we;
            beat_r <= LEN_W'(1);
        end else if (advance_s) begin
            beat_r <= last_beat_s ? {LEN_W{1'b0}} : beat_r + LEN_W'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // Address arithmetic is modulo 2**ADDR_W, so a burst wraps past the top of memory.
    assign beat_addr_s = base_r + ADDR_W'(beat_r);
    assign we_lat_s    = we_r;
    assign last_beat_s = (beat_r == LEN_W'(eff_len(32'(len_r), LEN_W) - 32'd1));
    assign single_s    = (eff_len(32'(dma_len), LEN_W) == 32'd1);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the
// DMA/debug burst port; DMA is guaranteed service after MAX_WAIT lost cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input logic           mem_clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int WAIT_W = 4;

    logic [0:0]        state_r, state_nxt_s;
    logic [WAIT_W-1:0] wait_r, wait_nxt_s;
    logic              dma_win_s, start_s, advance_s;
    logic              d_we_s, dma_ack_s, dma_done_s, cpu_stall_s;
    logic [ADDR_W-1:0] d_addr_s;
    logic [DATA_W-1:0] d_dataout_s;
    logic [ADDR_W-1:0] beat_addr_s;
    logic              we_lat_s, last_beat_s, single_s;

    dmem_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_ctr (
        .mem_clk     (mem_clk),
        .rst_n       (rst_n),
        .start_s     (start_s),
        .advance_s   (advance_s),
        .dma_we      (bus.dma_we),
        .dma_addr    (bus.dma_addr),
        .dma_len     (bus.dma_len),
        .beat_addr_s (beat_addr_s),
        .we_lat_s    (we_lat_s),
        .last_beat_s (last_beat_s),
        .single_s    (single_s)
    );

    // Grant decision, next-state logic and the memory-side output mux.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        dma_win_s   = 1'b0;
        start_s     = 1'b0;
        advance_s   = 1'b0;
        d_we_s      = 1'b0;
        d_addr_s    = {ADDR_W{1'b0}};
        d_dataout_s = {DATA_W{1'b0}};
        dma_ack_s   = 1'b0;
        dma_done_s  = 1'b0;
        cpu_stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dma_win_s = bus.dma_req && (!bus.cpu_req || (wait_r == WAIT_W'(MAX_WAIT)));
                if (dma_win_s) begin
                    start_s     = 1'b1;
                    d_we_s      = bus.dma_we;
                    d_addr_s    = bus.dma_addr;
                    d_dataout_s = bus.dma_wdata;
                    dma_ack_s   = 1'b1;
                    dma_done_s  = single_s;
                    cpu_stall_s = bus.cpu_req;
                    state_nxt_s = single_s ? ST_IDLE : ST_BURST;
                    wait_nxt_s  = {WAIT_W{1'b0}};
                end else if (bus.cpu_req) begin
                    d_we_s      = bus.cpu_we;
                    d_addr_s    = bus.cpu_addr;
                    d_dataout_s = bus.cpu_wdata;
                    if (bus.dma_req && (wait_r != WAIT_W'(MAX_WAIT))) begin
                        wait_nxt_s = wait_r + WAIT_W'(1);
                    end else if (bus.dma_req) begin
                        wait_nxt_s = wait_r;
                    end else begin
                        wait_nxt_s = {WAIT_W{1'b0}};
                    end
                end else begin
                    wait_nxt_s = {WAIT_W{1'b0}};
                end
            end
            ST_BURST: begin
                // The burst is atomic: dma_req is not looked at until it completes.
                advance_s   = 1'b1;
                d_we_s      = we_lat_s;
                d_addr_s    = beat_addr_s;
                d_dataout_s = bus.dma_wdata;
                dma_ack_s   = 1'b1;
                cpu_stall_s = bus.cpu_req;
                if (last_beat_s) begin
                    dma_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                    wait_nxt_s  = {WAIT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wait_nxt_s  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // FSM state and starvation counter.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wait_r  <= {WAIT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    assign bus.d_we      = d_we_s;
    assign bus.d_addr    = d_addr_s;
    assign bus.d_dataout = d_dataout_s;
    assign bus.dma_ack   = dma_ack_s;
    assign bus.dma_done  = dma_done_s;
    assign bus.cpu_stall = cpu_stall_s;
    assign bus.cpu_rdata = bus.d_datain;
    assign bus.dma_rdata = bus.d_datain;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 256x16 Data_Memory.
module tb_dmem_arbiter;

    logic mem_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 mem_clk = ~mem_clk;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16), .LEN_W(4)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .LEN_W(4), .MAX_WAIT(4)) dut (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    logic [15:0] mem [256];
    assign bus.d_datain = mem[bus.d_addr];
    always @(posedge mem_clk) if (bus.d_we) mem[bus.d_addr] <= bus.d_dataout;

    typedef struct {
        string       tag;
        logic        is_dma;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        done;
        logic        stall;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    logic [15:0] data_seen;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push(input string tag, input logic is_dma, input logic we, input logic [7:0] addr,
                        input logic [15:0] data, input logic done, input logic stall);
        exp_t r;
        r.tag = tag; r.is_dma = is_dma; r.we = we; r.addr = addr;
        r.data = data; r.done = done; r.stall = stall;
        sb_q.push_back(r);
    endtask

    task automatic cyc();
        @(posedge mem_clk);
        #1;
    endtask

    function automatic logic [63:0] idle_vec();
        return {36'd0, bus.d_we, bus.d_addr, bus.d_dataout, bus.dma_ack, bus.dma_done, bus.cpu_stall};
    endfunction

    // Monitor: every performed access must match the next expected record.
    always @(negedge mem_clk) begin
        if (rst_n && (bus.dma_ack || (bus.cpu_req && !bus.cpu_stall))) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_access: got ack=%b addr=%h we=%b expected no access",
                         bus.dma_ack, bus.d_addr, bus.d_we);
            end else begin
                e = sb_q.pop_front();
                if (bus.dma_ack) data_seen = bus.d_we ? bus.d_dataout : bus.dma_rdata;
                else             data_seen = bus.d_we ? bus.d_dataout : bus.cpu_rdata;
                check(e.tag, {36'd0, bus.dma_ack, bus.d_we, bus.d_addr, data_seen, bus.dma_done, bus.cpu_stall},
                             {36'd0, e.is_dma, e.we, e.addr, e.data, e.done, e.stall});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 16'h0000;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 8'h00; bus.dma_len = 4'h0;
        bus.dma_wdata = 16'h0000;

        repeat (2) @(posedge mem_clk);
        #1;
        check("reset_outputs", idle_vec(), 64'd0);
        rst_n = 1'b1;
        cyc();
        check("idle_outputs", idle_vec(), 64'd0);

        // CPU alone: write then read back
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 16'hABCD;
        push("cpu_write", 1'b0, 1'b1, 8'h10, 16'hABCD, 1'b0, 1'b0);
        cyc();
        bus.cpu_we = 1'b0; bus.cpu_wdata = 16'h0000;
        push("cpu_read", 1'b0, 1'b0, 8'h10, 16'hABCD, 1'b0, 1'b0);
        cyc();
        bus.cpu_req = 1'b0;

        // DMA write burst wrapping past 8'hFF
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'hFE; bus.dma_len = 4'd3; bus.dma_wdata = 16'd1;
        push("dma_wr_b0", 1'b1, 1'b1, 8'hFE, 16'd1, 1'b0, 1'b0);
        cyc();
        bus.dma_req = 1'b0; bus.dma_wdata = 16'd2;
        push("dma_wr_b1", 1'b1, 1'b1, 8'hFF, 16'd2, 1'b0, 1'b0);
        cyc();
        bus.dma_wdata = 16'd3;
        push("dma_wr_b2", 1'b1, 1'b1, 8'h00, 16'd3, 1'b1, 1'b0);
        cyc();
        bus.dma_wdata = 16'd0;
        cyc();
        check("dma_wrap_mem", {16'd0, mem[8'hFE], mem[8'hFF], mem[8'h00]}, {16'd0, 16'd1, 16'd2, 16'd3});

        // Contention: CPU wins 4 cycles, DMA 2 beats with stall, CPU resumes
        cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 16'hC001;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h10; bus.dma_len = 4'd2;
        push("cont_cpu0", 1'b0, 1'b1, 8'h20, 16'hC001, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            cyc();
            bus.cpu_addr = 8'h20 + 8'(k); bus.cpu_wdata = 16'hC001 + 16'(k);
            push("cont_cpu", 1'b0, 1'b1, 8'h20 + 8'(k), 16'hC001 + 16'(k), 1'b0, 1'b0);
        end
        cyc();
        bus.cpu_addr = 8'h24; bus.cpu_wdata = 16'hC005;
        push("cont_dma_b0", 1'b1, 1'b0, 8'h10, 16'hABCD, 1'b0, 1'b1);
        cyc();
        bus.dma_req = 1'b0;
        push("cont_dma_b1", 1'b1, 1'b0, 8'h11, 16'h5A11, 1'b1, 1'b1);
        cyc();
        push("cont_cpu_resume", 1'b0, 1'b1, 8'h24, 16'hC005, 1'b0, 1'b0);
        cyc();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;

        // len 0 read burst: 16 beats from 8'h00
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h00; bus.dma_len = 4'd0;
        push("len0_b0", 1'b1, 1'b0, 8'h00, 16'h0003, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            cyc();
            bus.dma_req = 1'b0;
            push("len0_beat", 1'b1, 1'b0, 8'(k), 16'h5A00 | 16'(k), (k == 15), 1'b0);
        end
        cyc();

        // Reset during beat 2 of a 5-beat write
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h40; bus.dma_len = 4'd5; bus.dma_wdata = 16'hD000;
        push("rst_b0", 1'b1, 1'b1, 8'h40, 16'hD000, 1'b0, 1'b0);
        cyc();
        bus.dma_req = 1'b0; bus.dma_wdata = 16'hD001;
        push("rst_b1", 1'b1, 1'b1, 8'h41, 16'hD001, 1'b0, 1'b0);
        cyc();
        bus.dma_wdata = 16'hD002;
        rst_n = 1'b0;
        #1;
        check("reset_mid_burst", idle_vec(), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        check("idle_after_reset", idle_vec(), 64'd0);
        check("rst_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]},
                         {16'hD000, 16'hD001, 16'h5A42, 16'h5A43});
        check("rst_mem_b4", {48'd0, mem[8'h44]}, {48'd0, 16'h5A44});

        cyc();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
